// File: rtl/vram_fill_pkg.sv
// vram_fill_pkg: shared modes, FSM states and verify delay-line entry for the VRAM region filler
package vram_fill_pkg;
   localparam int FILL_ADDR_MAX = 32;
   localparam int FILL_DATA_MAX = 32;
   typedef enum logic [1:0] {FILL_CONST, FILL_INCR, FILL_CHECKER, FILL_VERIFY} fill_mode_e;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fill_state_e;
   // Fields are sized for the widest supported VRAM; users narrow them with casts.
   typedef struct packed {
      logic [FILL_ADDR_MAX-1:0] addr;
      logic [FILL_DATA_MAX-1:0] expected;
   } verify_entry_t;
endpackage

// File: rtl/vram_fill_pattern_gen_m.sv
// vram_fill_pattern_gen_m: fill pattern source; accumulator for INCR/VERIFY, parity select for CHECKER
module vram_fill_pattern_gen_m
   import vram_fill_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)(
   input  logic                  clk_12_5875,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  advance,
   input  fill_mode_e            mode,
   input  logic [DATA_WIDTH-1:0] fill_value,
   input  logic [DATA_WIDTH-1:0] step,
   output logic [DATA_WIDTH-1:0] pattern
);
   logic [DATA_WIDTH-1:0] seed, inc, acc;
   logic odd;
   always_ff @(posedge clk_12_5875 or negedge rst_n)
      if (!rst_n) begin
         seed <= '0;
         inc  <= '0;
         acc  <= '0;
         odd  <= 1'b0;
      end else if (load) begin
         seed <= fill_value;
         inc  <= step;
         acc  <= fill_value;
         odd  <= 1'b0;
      end else if (advance) begin
         acc <= acc + inc;
         odd <= ~odd;
      end
   always_comb pattern = mode == FILL_CHECKER ? (odd ? ~seed : seed) : mode == FILL_CONST ? seed : acc;
endmodule

// File: rtl/vram_region_fill_m.sv
// vram_region_fill_m: fills or verifies a [base, base+length) VRAM region through a granted arbiter port
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif
`ifndef VRAM_SIZE
`define VRAM_SIZE 4096
`endif
module vram_region_fill_m
   import vram_fill_pkg::*;
#(
   parameter int ADDR_WIDTH    = `VRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH    = 8,
   parameter int MEM_SIZE      = `VRAM_SIZE,
   parameter int READ_LATENCY  = 1,
   parameter int ERR_CNT_WIDTH = 8
)(
   input  logic                     clk_12_5875,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [1:0]               mode,
   input  logic [ADDR_WIDTH-1:0]    base_addr,
   input  logic [ADDR_WIDTH:0]      length,
   input  logic [DATA_WIDTH-1:0]    fill_value,
   input  logic [DATA_WIDTH-1:0]    step,
   input  logic                     grant,
   input  logic [DATA_WIDTH-1:0]    rdata,
   output logic [ADDR_WIDTH-1:0]    address,
   output logic [DATA_WIDTH-1:0]    data,
   output logic                     write_enable,
   output logic                     read_enable,
   output logic                     in_progress,
   output logic                     done,
   output logic                     error,
   output logic [ADDR_WIDTH-1:0]    err_addr,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);
   fill_state_e state;
   fill_mode_e mode_q;
   logic [ADDR_WIDTH:0] rem;
   logic [ADDR_WIDTH+1:0] end_addr;
   logic [READ_LATENCY-1:0] dl_v;
   verify_entry_t dl [READ_LATENCY];
   logic idle_start, range_err, run, verify, accept, last, mismatch, drain_empty;
   assign idle_start   = state == S_IDLE && start;
   assign end_addr     = (ADDR_WIDTH+2)'(base_addr) + (ADDR_WIDTH+2)'(length);
   assign range_err    = end_addr > (ADDR_WIDTH+2)'(MEM_SIZE);
   assign run          = state == S_RUN;
   assign verify       = mode_q == FILL_VERIFY;
   assign write_enable = run && !verify;
   assign read_enable  = run && verify;
   assign accept       = run && grant;
   assign last         = rem == (ADDR_WIDTH+1)'(1);
   assign in_progress  = state != S_IDLE;
   assign done         = state == S_DONE;
   assign mismatch     = dl_v[READ_LATENCY-1] && rdata != DATA_WIDTH'(dl[READ_LATENCY-1].expected);
   // Only the oldest entry can be in flight if nothing survives the next shift.
   assign drain_empty  = (dl_v << 1) == '0;
   always_ff @(posedge clk_12_5875 or negedge rst_n)
      if (!rst_n) begin
         state   <= S_IDLE;
         mode_q  <= FILL_CONST;
         rem     <= '0;
         address <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state   <= range_err || length == '0 ? S_DONE : S_RUN;
               mode_q  <= fill_mode_e'(mode);
               rem     <= length;
               address <= base_addr;
            end
            S_RUN: begin
               if (accept) begin
                  rem     <= rem - (ADDR_WIDTH+1)'(1);
                  address <= address + ADDR_WIDTH'(1);
               end
               if (abort || (accept && last)) state <= verify ? S_DRAIN : S_DONE;
            end
            S_DRAIN: if (drain_empty) state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   always_ff @(posedge clk_12_5875 or negedge rst_n)
      if (!rst_n) dl_v <= '0;
      else dl_v <= READ_LATENCY'({dl_v, accept && verify});
   always_ff @(posedge clk_12_5875) begin
      dl[0] <= '{addr: FILL_ADDR_MAX'(address), expected: FILL_DATA_MAX'(data)};
      for (int k = 1; k < READ_LATENCY; k++) dl[k] <= dl[k-1];
   end
   always_ff @(posedge clk_12_5875 or negedge rst_n)
      if (!rst_n) begin
         error     <= 1'b0;
         err_count <= '0;
         err_addr  <= '0;
      end else if (idle_start) begin
         error     <= range_err;
         err_count <= '0;
         err_addr  <= '0;
      end else if (mismatch) begin
         error <= 1'b1;
         if (err_count == '0) err_addr <= ADDR_WIDTH'(dl[READ_LATENCY-1].addr);
         if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
   vram_fill_pattern_gen_m #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
      .clk_12_5875(clk_12_5875),
      .rst_n(rst_n),
      .load(idle_start),
      .advance(accept),
      .mode(mode_q),
      .fill_value(fill_value),
      .step(step),
      .pattern(data)
   );
endmodule
